// File: rtl/seq_pattern_gen_pkg.sv
// Shared types and default sizing for the serial pattern generator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package seq_pattern_gen_pkg;

    // Default sizing; the module takes these as parameter defaults.
    localparam int unsigned c_nbits_dflt = 8;
    localparam int unsigned c_rbits_dflt = 4;

    // Width of a length field (holds 0..p_nbits) and of a bit index (0..p_nbits-1).
    localparam int unsigned c_lenbits = $clog2(c_nbits_dflt) + 1;
    localparam int unsigned c_idxbits = $clog2(c_nbits_dflt);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern transmitter: shifts a 1..p_nbits pattern out MSB-first, repeat_+1 times.
// Latency: first bit is visible the cycle after the accepting edge; back-to-back commands leave no gap.
// Backpressure: start_rdy is high in IDLE and on the final bit only; offers at other times are ignored.
//
// Ports:
//   clk, reset             - clock, synchronous active-high reset
//   start_val / start_rdy  - command handshake; pattern, len, repeat_ sampled on the firing edge
//   pattern, len, repeat_  - bits to send ([len-1] first), bits per pass, extra passes
//   out, out_val, last     - serial bit, bit qualifier, final bit of final pass
module seq_pattern_gen
    import seq_pattern_gen_pkg::*;
#(
    parameter int unsigned p_nbits = c_nbits_dflt,
    parameter int unsigned p_rbits = c_rbits_dflt
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_val,
    output logic                     start_rdy,
    input  logic [p_nbits-1:0]       pattern,
    input  logic [$clog2(p_nbits):0] len,
    input  logic [p_rbits-1:0]       repeat_,
    output logic                     out,
    output logic                     out_val,
    output logic                     last
);

    localparam int unsigned lw = $clog2(p_nbits) + 1;
    localparam int unsigned iw = $clog2(p_nbits);

    state_t             state;
    state_t             state_nxt;
    logic [p_nbits-1:0] pat_r;
    logic [lw-1:0]      len_r;
    logic [iw-1:0]      bit_idx;
    logic [p_rbits-1:0] rep_cnt;

    logic               fire;
    logic               load;
    logic               final_bit;
    logic [lw-1:0]      len_eff;
    logic [lw-1:0]      len_m1;
    logic [lw-1:0]      len_r_m1;

    // Over-long lengths are clamped at capture so the index never exceeds the pattern.
    assign len_eff   = (len > lw'(p_nbits)) ? lw'(p_nbits) : len;
    assign len_m1    = len_eff - lw'(1);
    assign len_r_m1  = len_r - lw'(1);
    assign final_bit = (state == SEND) && (bit_idx == '0) && (rep_cnt == '0);
    assign fire      = start_val && start_rdy;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. A zero-length command completes the handshake but loads nothing,
    // so the block lands in (or stays in) IDLE.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (fire && (len_eff != '0)) begin
                    state_nxt = SEND;
                    load      = 1'b1;
                end
            end
            SEND: begin
                if (final_bit) begin
                    if (fire && (len_eff != '0)) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers: pattern, length, bit index within a pass, passes remaining.
    always_ff @(posedge clk) begin
        if (reset) begin
            pat_r   <= '0;
            len_r   <= '0;
            bit_idx <= '0;
            rep_cnt <= '0;
        end else if (load) begin
            pat_r   <= pattern;
            len_r   <= len_eff;
            bit_idx <= len_m1[iw-1:0];
            rep_cnt <= repeat_;
        end else if (state == SEND) begin
            if (bit_idx != '0) begin
                bit_idx <= bit_idx - 1'b1;
            end else if (rep_cnt != '0) begin
                // End of a pass with passes left: restart the pattern from its MSB.
                rep_cnt <= rep_cnt - 1'b1;
                bit_idx <= len_r_m1[iw-1:0];
            end
        end
    end

    // Moore outputs, from registers only.
    always_comb begin
        out       = 1'b0;
        out_val   = 1'b0;
        last      = 1'b0;
        start_rdy = 1'b1;
        if (state == SEND) begin
            out       = pat_r[bit_idx];
            out_val   = 1'b1;
            last      = final_bit;
            start_rdy = final_bit;
        end
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
module tb_seq_pattern_gen;

    localparam int NB = 8;
    localparam int RB = 4;

    logic          clk;
    logic          reset;
    logic          start_val;
    logic          start_rdy;
    logic [NB-1:0] pattern;
    logic [3:0]    len;
    logic [RB-1:0] repeat_;
    logic          out;
    logic          out_val;
    logic          last;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference: the exact remaining output stream as a queue of {bit, last} entries.
    logic [1:0] q[$];

    seq_pattern_gen #(.p_nbits(NB), .p_rbits(RB)) dut (
        .clk       (clk),
        .reset     (reset),
        .start_val (start_val),
        .start_rdy (start_rdy),
        .pattern   (pattern),
        .len       (len),
        .repeat_   (repeat_),
        .out       (out),
        .out_val   (out_val),
        .last      (last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {out, out_val, last, start_rdy} for the current cycle.
    function automatic logic [3:0] model_vec();
        if (q.size() == 0) return 4'b0001;
        return {q[0][1], 1'b1, q[0][0], q[0][0]};
    endfunction

    // Drive inputs for one cycle, advance the model across the coming edge,
    // and return at the following falling edge with outputs settled.
    task automatic cyc(input logic sv, input logic [NB-1:0] pat, input logic [3:0] ln,
                       input logic [RB-1:0] rp, input logic rst);
        logic rdy;
        int   l;
        start_val = sv;
        pattern   = pat;
        len       = ln;
        repeat_   = rp;
        reset     = rst;
        rdy = (q.size() == 0) || q[0][0];
        if (rst) begin
            q.delete();
        end else begin
            if (q.size() > 0) void'(q.pop_front());
            if (sv && rdy) begin
                l = (ln > NB) ? NB : int'(ln);
                for (int r = 0; r <= int'(rp); r++)
                    for (int i = l - 1; i >= 0; i--)
                        q.push_back({pat[i], (r == int'(rp)) && (i == 0)});
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic test_reset();
        cyc(1'b1, 8'hFF, 4'd3, 4'd1, 1'b1);
        cyc(1'b0, 8'h00, 4'd0, 4'd0, 1'b1);
        n_chk++;
        if ({out, out_val, last, start_rdy} !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_state: out/val/last/rdy=%b%b%b%b expected 0001",
                     out, out_val, last, start_rdy);
        end
        idle();
    endtask

    task automatic test_basic();
        logic [3:0] bits, vals, lasts, rdys;
        cyc(1'b1, 8'b00000101, 4'd3, 4'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if ({out, out_val, last, start_rdy} !== model_vec()) begin
                n_fail++;
                $display("FAIL basic cyc%0d: got %b%b%b%b expected %b", k, out, out_val, last, start_rdy, model_vec());
            end
            bits = {bits[2:0], out}; vals = {vals[2:0], out_val};
            lasts = {lasts[2:0], last}; rdys = {rdys[2:0], start_rdy};
            idle();
        end
        n_chk++;
        if ({bits, vals, lasts, rdys} !== {4'b1010, 4'b1110, 4'b0010, 4'b0011}) begin
            n_fail++;
            $display("FAIL basic_stream: bits/val/last/rdy=%b %b %b %b expected 1010 1110 0010 0011",
                     bits, vals, lasts, rdys);
        end
    endtask

    task automatic test_repeat();
        logic [11:0] bits, lasts;
        int nv = 0;
        cyc(1'b1, 8'b00001101, 4'd4, 4'd2, 1'b0);
        for (int k = 0; k < 13; k++) begin
            n_chk++;
            if ({out, out_val, last, start_rdy} !== model_vec()) begin
                n_fail++;
                $display("FAIL repeat cyc%0d: got %b%b%b%b expected %b", k, out, out_val, last, start_rdy, model_vec());
            end
            if (k < 12) begin
                bits = {bits[10:0], out}; lasts = {lasts[10:0], last};
                nv += int'(out_val);
            end
            idle();
        end
        n_chk++;
        if (bits !== 12'b110111011101 || lasts !== 12'b000000000001 || nv != 12) begin
            n_fail++;
            $display("FAIL repeat_stream: bits=%b last=%b nval=%0d expected 110111011101 000000000001 12",
                     bits, lasts, nv);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] bits, vals, lasts;
        cyc(1'b1, 8'b00000101, 4'd3, 4'd0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            n_chk++;
            if ({out, out_val, last, start_rdy} !== model_vec()) begin
                n_fail++;
                $display("FAIL b2b cyc%0d: got %b%b%b%b expected %b", k, out, out_val, last, start_rdy, model_vec());
            end
            bits = {bits[3:0], out}; vals = {vals[3:0], out_val}; lasts = {lasts[3:0], last};
            // Offer the second command while the first is on its final bit.
            if (k == 2) cyc(1'b1, 8'b00000010, 4'd2, 4'd0, 1'b0);
            else idle();
        end
        n_chk++;
        if ({bits, vals, lasts} !== {5'b10110, 5'b11111, 5'b00101}) begin
            n_fail++;
            $display("FAIL b2b_stream: bits/val/last=%b %b %b expected 10110 11111 00101", bits, vals, lasts);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        cyc(1'b1, 8'hA5, 4'd8, 4'd0, 1'b0);
        idle();
        n_chk++;
        if ({out, out_val} !== 2'b01) begin
            n_fail++;
            $display("FAIL rstmid_bit2: out/val=%b%b expected 01", out, out_val);
        end
        cyc(1'b0, '0, '0, '0, 1'b1);
        n_chk++;
        if ({out_val, last, start_rdy} !== 3'b001) begin
            n_fail++;
            $display("FAIL rstmid_abort: val/last/rdy=%b%b%b expected 001", out_val, last, start_rdy);
        end
        cyc(1'b1, 8'b00000110, 4'd3, 4'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if ({out, out_val, last, start_rdy} !== model_vec()) begin
                n_fail++;
                $display("FAIL rstmid_restart cyc%0d: got %b%b%b%b expected %b", k, out, out_val, last, start_rdy, model_vec());
            end
            idle();
        end
    endtask

    task automatic test_len_zero();
        cyc(1'b1, 8'hFF, 4'd0, 4'd3, 1'b0);
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if ({out_val, last, start_rdy} !== 3'b001) begin
                n_fail++;
                $display("FAIL len0 cyc%0d: val/last/rdy=%b%b%b expected 001", k, out_val, last, start_rdy);
            end
            idle();
        end
        // Zero-length command accepted on a final bit: block returns to IDLE afterwards.
        cyc(1'b1, 8'h01, 4'd1, 4'd0, 1'b0);
        n_chk++;
        if ({out, out_val, last, start_rdy} !== 4'b1111) begin
            n_fail++;
            $display("FAIL len0_single: got %b%b%b%b expected 1111", out, out_val, last, start_rdy);
        end
        cyc(1'b1, 8'hFF, 4'd0, 4'd2, 1'b0);
        n_chk++;
        if ({out_val, last, start_rdy} !== 3'b001) begin
            n_fail++;
            $display("FAIL len0_on_last: val/last/rdy=%b%b%b expected 001", out_val, last, start_rdy);
        end
        idle();
    endtask

    task automatic test_len_clamp();
        int ones = 0, nv = 0;
        cyc(1'b1, 8'hFF, 4'd9, 4'd0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            n_chk++;
            if ({out, out_val, last, start_rdy} !== model_vec()) begin
                n_fail++;
                $display("FAIL clamp cyc%0d: got %b%b%b%b expected %b", k, out, out_val, last, start_rdy, model_vec());
            end
            ones += int'(out && out_val);
            nv   += int'(out_val);
            idle();
        end
        n_chk++;
        if (ones != 8 || nv != 8) begin
            n_fail++;
            $display("FAIL clamp_count: ones=%0d bits=%0d expected 8 8", ones, nv);
        end
    endtask

    task automatic test_max_repeat();
        int nv = 0, last_at = -1, nlast = 0, k = 0;
        cyc(1'b1, 8'($urandom), 4'd8, 4'd15, 1'b0);
        while (out_val === 1'b1 && k < 300) begin
            k++;
            nv++;
            if (last === 1'b1) begin
                last_at = nv;
                nlast++;
            end
            n_chk++;
            if ({out, out_val, last, start_rdy} !== model_vec()) begin
                n_fail++;
                $display("FAIL maxrep bit%0d: got %b%b%b%b expected %b", nv, out, out_val, last, start_rdy, model_vec());
            end
            idle();
        end
        n_chk++;
        if (nv != 128 || last_at != 128 || nlast != 1) begin
            n_fail++;
            $display("FAIL maxrep_count: bits=%0d last_at=%0d nlast=%0d expected 128 128 1", nv, last_at, nlast);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 200; k++) begin
            cyc(1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom_range(0, 10)),
                4'($urandom_range(0, 2)), ($urandom_range(0, 39) == 0));
            n_chk++;
            if ({out, out_val, last, start_rdy} !== model_vec()) begin
                n_fail++;
                $display("FAIL random cyc%0d: got %b%b%b%b expected %b", k, out, out_val, last, start_rdy, model_vec());
            end
        end
    endtask

    initial begin
        start_val = 1'b0;
        pattern   = '0;
        len       = '0;
        repeat_   = '0;
        reset     = 1'b1;
        test_reset();
        test_basic();
        test_repeat();
        test_back_to_back();
        test_reset_mid();
        test_len_zero();
        test_len_clamp();
        test_max_repeat();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
- Serial bit-pattern transmitter; produces the one-bit stream that the team's sequence-detector FSMs consume.
- Accepts a pattern of 1..p_nbits bits plus a repeat count over a val/rdy handshake.
- Shifts the pattern out MSB-first, one bit per cycle, with a valid qualifier and a last-bit flag.
- Drives detector benches and on-chip self-test stimulus.

Parameters:
- p_nbits, 8, maximum pattern length in bits.
- p_rbits, 4, width of the repeat count; the pattern is sent repeat+1 times.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start_val  input  1  a command is offered.
- start_rdy  output  1  the block can accept a command this cycle.
- pattern  input  p_nbits  bits to send; bit [len-1] goes first, bit [0] last.
- len  input  $clog2(p_nbits)+1  number of bits per pass.
- repeat_  input  p_rbits  extra passes; total passes = repeat_+1.
- out  output  1  serial bit.
- out_val  output  1  out carries a pattern bit this cycle.
- last  output  1  the current bit is the final bit of the final pass.

Behaviour:
- States: IDLE and SEND. Registers: pat_r, len_r, bit_idx, rep_cnt.
- Reset: synchronous. The state after the edge is IDLE, with out=0, out_val=0, last=0, start_rdy=1. All registers clear.
- Reset mid-SEND: the transfer is aborted at the next edge. The remaining bits are never emitted, and no last pulse is produced.
- Handshake: a transfer fires when start_val && start_rdy at a rising edge. pattern, len and repeat_ are sampled only at that edge.
- start_rdy = (state==IDLE) || (state==SEND && last). It is combinational from state registers only and never depends on start_val.
- Accept from IDLE at edge k: state=SEND after edge k, so the first bit is visible in the cycle following edge k (latency 1). Loads are bit_idx=len-1 and rep_cnt=repeat_.
- SEND outputs are Moore, from registers only:
  - out=pat_r[bit_idx] and out_val=1.
  - last=(bit_idx==0 && rep_cnt==0).
- SEND transitions at each edge:
  - bit_idx!=0: bit_idx decrements.
  - bit_idx==0 && rep_cnt!=0: rep_cnt decrements and bit_idx reloads to len_r-1.
  - bit_idx==0 && rep_cnt==0 (last): go to IDLE, unless a new command fires on the same edge.
- Back-to-back: if a command is accepted on the last-bit edge, the block reloads and stays in SEND. The first bit of the new pattern appears in the very next cycle, with no gap.
- IDLE outputs: out=0, out_val=0, last=0.
- len==0: the command is accepted (handshake completes) but emits nothing. The state goes to or stays in IDLE.
  - If accepted during the last bit, the block returns to IDLE after that bit.
- len>p_nbits: clamped to p_nbits at capture.
- Total bits emitted per command = len*(repeat_+1). The maximum is p_nbits*2^p_rbits with no overflow, because the counters are per-field.
- Inputs are ignored in SEND except on the last-bit cycle.
- start_val with start_rdy=0 has no effect. The offer does not need to be held by the block.

Decomposition:
- Shared package seq_pattern_gen_pkg:
  - state enum {IDLE, SEND}.
  - localparam c_lenbits = $clog2(p_nbits)+1.
  - localparam c_idxbits = $clog2(p_nbits).
- Single module; no sub-module is needed. The bit index and repeat counter are plain registers in the datapath always block.
- The next-state/output logic and the register block are kept separate.

Test Plan:
- Reset, then pattern=8'b00000101, len=3, repeat_=0, start_val for one cycle → out 1,0,1 over 3 cycles. out_val=1,1,1; last=0,0,1; start_rdy=0,0,1; then IDLE with out_val=0.
- pattern=8'b00001101, len=4, repeat_=2 → 12 bits 1101 1101 1101 with out_val continuously 1. last only on bit 12.
- Back-to-back: during the last bit of the 3'b101 command, present len=2, pattern=2'b10 → stream 1,0,1,1,0 with no out_val gap. last on bits 3 and 5.
- Reset asserted on the 2nd bit of len=8, pattern=8'hA5 → next cycle out_val=0 and start_rdy=1 with no last pulse. A new command afterward starts cleanly.
- Boundaries:
  - len=0, repeat_=3 → handshake accepted, out_val stays 0.
  - len=9 with p_nbits=8, pattern=8'hFF → exactly 8 ones.
  - repeat_=15, len=8 → 128 bits, last on bit 128.
- Random: 200 cycles of random start_val/pattern/len/repeat_/reset against a behavioural model → out, out_val, last and start_rdy match every cycle.
